// File: rtl/effect_param_controller_pkg.sv
// Shared types and defaults for the effect parameter controller.
// Holds the key conditioner state enum, default parameter tables and SW bit positions.
package effect_ctrl_pkg;

    typedef enum logic [2:0] {
        KEY_RELEASED   = 3'd0,
        KEY_PRESS_DB   = 3'd1,
        KEY_HELD       = 3'd2,
        KEY_REPEAT     = 3'd3,
        KEY_RELEASE_DB = 3'd4
    } key_state_e;

    localparam int SW_W       = 10;
    localparam int SW_SEL_LSB = 0;
    localparam int SW_SEL_MSB = 3;
    localparam int SW_EN_BIT  = 6;

    // Packed tables: element 0 sits in the low word.
    localparam logic [1:0][31:0] DEF_P_MIN  = {32'd1, 32'd4};
    localparam logic [1:0][31:0] DEF_P_MAX  = {32'd6, 32'd128};
    localparam logic [1:0][31:0] DEF_P_STEP = {32'd1, 32'd4};
    localparam logic [1:0][31:0] DEF_P_INIT = {32'd1, 32'd64};

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/effect_param_controller_if.sv
// Key, switch and parameter-value bundle between the front panel and the controller.
// master drives keys and switches; slave (the controller) drives the parameter outputs.
interface effect_param_controller_if #(
    parameter int NUM_PARAMS = 2,
    parameter int PARAM_W    = 32
);
    import effect_ctrl_pkg::*;

    logic                                 key_dec;
    logic                                 key_inc;
    logic [SW_W-1:0]                      SW;
    logic [NUM_PARAMS-1:0][PARAM_W-1:0]   param_val;
    logic [NUM_PARAMS-1:0]                param_changed;
    logic                                 disabled;

    modport master (
        output key_dec, key_inc, SW,
        input  param_val, param_changed, disabled
    );

    modport slave (
        input  key_dec, key_inc, SW,
        output param_val, param_changed, disabled
    );

endinterface

// File: rtl/effect_param_controller_key_conditioner.sv
// Synchronise, debounce and auto-repeat one active-low key into single-cycle step pulses.
// Step fires DEBOUNCE_CYCLES synced-low cycles after press, then every REPEAT_RATE after REPEAT_DELAY; no backpressure.
module key_conditioner
    import effect_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic step
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q, sync_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             was_rep_q, was_rep_d;
    logic             key_low;

    // Synchroniser idles at the released level so reset never looks like a press.
    assign sync_d  = {sync_q[0], key_n};
    assign key_low = ~sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        was_rep_d = was_rep_q;
        step      = 1'b0;
        unique case (state_q)
            KEY_RELEASED: begin
                if (key_low) begin
                    state_d = KEY_PRESS_DB;
                    cnt_d   = CNT_ONE;
                end
            end
            KEY_PRESS_DB: begin
                if (!key_low) begin
                    state_d = KEY_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = KEY_HELD;
                    cnt_d   = '0;
                    step    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_HELD: begin
                if (!key_low) begin
                    state_d   = KEY_RELEASE_DB;
                    cnt_d     = CNT_ONE;
                    was_rep_d = 1'b0;
                end else if (cnt_q >= RD_LAST) begin
                    state_d = KEY_REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_REPEAT: begin
                if (!key_low) begin
                    state_d   = KEY_RELEASE_DB;
                    cnt_d     = CNT_ONE;
                    was_rep_d = 1'b1;
                end else if (cnt_q >= RR_LAST) begin
                    cnt_d = '0;
                    step  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_RELEASE_DB: begin
                // A bounce back low resumes the hold phase it came from.
                if (key_low) begin
                    state_d = was_rep_q ? KEY_REPEAT : KEY_HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = KEY_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = KEY_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= 2'b11;
            state_q   <= KEY_RELEASED;
            cnt_q     <= '0;
            was_rep_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            was_rep_q <= was_rep_d;
        end
    end

endmodule

// File: rtl/effect_param_controller.sv
// Front-panel effect parameter store: key steps adjust the SW-selected parameter with saturation.
// param_val updates on the edge after a step, param_changed pulses the following cycle; no backpressure.
module effect_param_controller
    import effect_ctrl_pkg::*;
#(
    parameter int NUM_PARAMS      = 2,
    parameter int PARAM_W         = 32,
    parameter int SEL_BASE        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter logic [NUM_PARAMS-1:0][PARAM_W-1:0] P_MIN  = DEF_P_MIN,
    parameter logic [NUM_PARAMS-1:0][PARAM_W-1:0] P_MAX  = DEF_P_MAX,
    parameter logic [NUM_PARAMS-1:0][PARAM_W-1:0] P_STEP = DEF_P_STEP,
    parameter logic [NUM_PARAMS-1:0][PARAM_W-1:0] P_INIT = DEF_P_INIT
) (
    input  logic                      CLK,
    input  logic                      RST,
    effect_param_controller_if.slave  io
);

    localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
    localparam logic [4:0] SEL_LO = 5'(SEL_BASE);
    localparam logic [4:0] SEL_HI = 5'(SEL_BASE + NUM_PARAMS);

    logic inc_step, dec_step;

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_key_inc (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (io.key_inc),
        .step  (inc_step)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_key_dec (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (io.key_dec),
        .step  (dec_step)
    );

    logic [4:0]       sel_ext;
    logic             sel_ok;
    logic [IDX_W-1:0] sel_idx;
    logic             unused_sw;

    // Selection is read live every cycle, so switching SW mid-hold redirects repeats.
    assign sel_ext   = {1'b0, io.SW[SW_SEL_MSB:SW_SEL_LSB]};
    assign sel_ok    = (sel_ext >= SEL_LO) && (sel_ext < SEL_HI);
    assign sel_idx   = IDX_W'(sel_ext - SEL_LO);
    assign unused_sw = ^{io.SW[9:7], io.SW[5:4]};

    logic [NUM_PARAMS-1:0][PARAM_W-1:0] val_q, val_d;
    logic [NUM_PARAMS-1:0]              chg_q, chg_d;
    logic                               dis_q, dis_d;
    logic [PARAM_W:0]                   cur_w, lim_w;
    logic [PARAM_W-1:0]                 nxt;

    always_comb begin
        val_d = val_q;
        chg_d = '0;
        cur_w = '0;
        lim_w = '0;
        nxt   = '0;
        dis_d = ~io.SW[SW_EN_BIT];
        // Simultaneous inc and dec cancel out.
        if (sel_ok && (inc_step ^ dec_step)) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (sel_idx == IDX_W'(i)) begin
                    cur_w = {1'b0, val_q[i]};
                    if (inc_step) begin
                        lim_w = cur_w + {1'b0, P_STEP[i]};
                        nxt   = (lim_w > {1'b0, P_MAX[i]}) ? P_MAX[i] : lim_w[PARAM_W-1:0];
                    end else begin
                        lim_w = {1'b0, P_MIN[i]} + {1'b0, P_STEP[i]};
                        nxt   = (cur_w < lim_w) ? P_MIN[i]
                                                : PARAM_W'(cur_w - {1'b0, P_STEP[i]});
                    end
                    val_d[i] = nxt;
                    chg_d[i] = (nxt != val_q[i]);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            val_q <= P_INIT;
            chg_q <= '0;
            dis_q <= 1'b1;
        end else begin
            val_q <= val_d;
            chg_q <= chg_d;
            dis_q <= dis_d;
        end
    end

    assign io.param_val     = val_q;
    assign io.param_changed = chg_q;
    assign io.disabled      = dis_q;

endmodule

// File: tb/tb_effect_param_controller.sv
// Directed bench for effect_param_controller with a count-based reference model.
module tb_effect_param_controller;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam int GAP = 30;

    localparam int T_MIN  [2] = '{4, 1};
    localparam int T_MAX  [2] = '{128, 6};
    localparam int T_STEP [2] = '{4, 1};
    localparam int T_INIT [2] = '{64, 1};

    logic clk;
    logic rst;

    effect_param_controller_if #(.NUM_PARAMS(2), .PARAM_W(32)) io ();

    effect_param_controller #(
        .NUM_PARAMS      (2),
        .PARAM_W         (32),
        .SEL_BASE        (4),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a key step is due when the synchronised level has been low
    // for DB samples, then every RR samples once DB+RD+RR samples have elapsed.
    logic [31:0] m_val [2];
    logic [1:0]  m_chg;
    logic        m_dis;
    logic        hi1, hi2, hd1, hd2;
    int          run_i, run_d;

    function automatic bit step_due(input int run);
        return (run == DB) || (run >= DB + RD + RR && ((run - DB - RD) % RR) == 0);
    endfunction

    always @(posedge clk) begin : model
        bit s_i, s_d, ui, ud;
        int k, ov, nv, sel;
        if (rst) begin
            for (int i = 0; i < 2; i++) m_val[i] = T_INIT[i];
            m_chg = '0;
            m_dis = 1'b1;
            hi1 = 1'b1; hi2 = 1'b1; hd1 = 1'b1; hd2 = 1'b1;
            run_i = 0; run_d = 0;
        end else begin
            s_i = hi2; hi2 = hi1; hi1 = io.key_inc;
            s_d = hd2; hd2 = hd1; hd1 = io.key_dec;
            run_i = s_i ? 0 : run_i + 1;
            run_d = s_d ? 0 : run_d + 1;
            ui = step_due(run_i);
            ud = step_due(run_d);
            m_chg = '0;
            m_dis = ~io.SW[6];
            sel = int'(io.SW[3:0]);
            if (ui != ud && sel >= 4 && sel < 6) begin
                k  = sel - 4;
                ov = int'(m_val[k]);
                if (ui) nv = (ov + T_STEP[k] > T_MAX[k]) ? T_MAX[k] : ov + T_STEP[k];
                else    nv = (ov - T_STEP[k] < T_MIN[k]) ? T_MIN[k] : ov - T_STEP[k];
                m_val[k] = 32'(nv);
                m_chg[k] = (nv != ov);
            end
        end
    end

    int total_checks;
    int passed_checks;
    int pc0, pc1;
    bit chk_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, b1;
        total_checks = 0; passed_checks = 0;
        pc0 = 0; pc1 = 0; chk_en = 1'b0;
        rst = 1'b1;
        io.key_inc = 1'b1;
        io.key_dec = 1'b1;
        io.SW = 10'h000;

        fork
            forever begin
                @(negedge clk);
                if (io.param_changed[0] === 1'b1) pc0++;
                if (io.param_changed[1] === 1'b1) pc1++;
                if (chk_en) begin
                    check("cyc_val0", 64'(io.param_val[0]), 64'(m_val[0]));
                    check("cyc_val1", 64'(io.param_val[1]), 64'(m_val[1]));
                    check("cyc_changed", 64'(io.param_changed), 64'(m_chg));
                    check("cyc_disabled", 64'(io.disabled), 64'(m_dis));
                end
            end
        join_none

        tick(3);
        check("rst_val0", 64'(io.param_val[0]), 64'd64);
        check("rst_val1", 64'(io.param_val[1]), 64'd1);
        check("rst_changed", 64'(io.param_changed), 64'd0);
        check("rst_disabled", 64'(io.disabled), 64'd1);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single short increment press on parameter 0.
        io.SW = 10'h044;
        b0 = pc0; b1 = pc1;
        io.key_inc = 1'b0; tick(10); io.key_inc = 1'b1; tick(GAP);
        check("inc_val0", 64'(io.param_val[0]), 64'd68);
        check("inc_model_val0", 64'(m_val[0]), 64'd68);
        check("inc_pulses0", 64'(pc0 - b0), 64'd1);
        check("inc_val1", 64'(io.param_val[1]), 64'd1);
        check("inc_disabled", 64'(io.disabled), 64'd0);

        // Long hold on parameter 1 walks up and saturates at 6.
        io.SW = 10'h045;
        b1 = pc1;
        io.key_inc = 1'b0; tick(100); io.key_inc = 1'b1; tick(GAP);
        check("hold_val1", 64'(io.param_val[1]), 64'd6);
        check("hold_model_val1", 64'(m_val[1]), 64'd6);
        check("hold_pulses1", 64'(pc1 - b1), 64'd5);

        rst = 1'b1; tick(2); rst = 1'b0;
        check("rst2_val0", 64'(io.param_val[0]), 64'd64);

        // Three-cycle glitch is rejected.
        io.SW = 10'h044;
        b0 = pc0;
        io.key_dec = 1'b0; tick(3); io.key_dec = 1'b1; tick(GAP);
        check("glitch_val0", 64'(io.param_val[0]), 64'd64);
        check("glitch_pulses0", 64'(pc0 - b0), 64'd0);

        // Both keys together cancel.
        io.key_dec = 1'b0; io.key_inc = 1'b0; tick(10);
        io.key_dec = 1'b1; io.key_inc = 1'b1; tick(GAP);
        check("both_val0", 64'(io.param_val[0]), 64'd64);
        check("both_pulses0", 64'(pc0 - b0), 64'd0);

        // Invalid selection discards steps.
        io.SW = 10'h047;
        b1 = pc1;
        repeat (2) begin
            io.key_inc = 1'b0; tick(10); io.key_inc = 1'b1; tick(GAP);
        end
        check("badsel_val0", 64'(io.param_val[0]), 64'd64);
        check("badsel_val1", 64'(io.param_val[1]), 64'd1);
        check("badsel_pulses", 64'((pc0 - b0) + (pc1 - b1)), 64'd0);

        // Decrement into repeat down to 20, reset on the edge of the next step.
        io.SW = 10'h044;
        io.key_dec = 1'b0; tick(113);
        check("rep_val0", 64'(io.param_val[0]), 64'd20);
        check("rep_model_val0", 64'(m_val[0]), 64'd20);
        rst = 1'b1; tick(1);
        check("rep_rst_val0", 64'(io.param_val[0]), 64'd64);
        check("rep_rst_changed", 64'(io.param_changed), 64'd0);
        rst = 1'b0; tick(10);
        check("rep_redebounce_val0", 64'(io.param_val[0]), 64'd60);
        io.key_dec = 1'b1; tick(GAP);

        // Selection change mid-hold redirects repeat steps to parameter 1.
        io.key_inc = 1'b0; tick(38);
        io.SW = 10'h045; tick(14);
        io.key_inc = 1'b1; tick(GAP);
        check("redir_val0", 64'(io.param_val[0]), 64'd68);
        check("redir_val1", 64'(io.param_val[1]), 64'd3);

        // Effect enable off: disabled follows one cycle later.
        check("en_disabled_before", 64'(io.disabled), 64'd0);
        io.SW = 10'h005; tick(1);
        check("en_disabled_after", 64'(io.disabled), 64'd1);
        tick(5);
        check("en_val0", 64'(io.param_val[0]), 64'd68);
        check("en_val1", 64'(io.param_val[1]), 64'd3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/effect_param_controller.md
EFFECT_PARAM_CONTROLLER -- requirements
Module: effect_param_controller

Interface
REQ-001 Parameter NUM_PARAMS, default 2: number of adjustable effect parameters (1..8).
REQ-002 Parameter PARAM_W, default 32: width of each parameter value.
REQ-003 Parameter SEL_BASE, default 4: SW[3:0] code that selects parameter 0.
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000: cycles a key level must be stable before it is accepted.
REQ-005 Parameter REPEAT_DELAY, default 25000000: hold cycles before auto-repeat starts.
REQ-006 Parameter REPEAT_RATE, default 5000000: cycles between auto-repeat steps.
REQ-007 Parameter arrays P_MIN, P_MAX, P_STEP, P_INIT, each NUM_PARAMS x PARAM_W; defaults {4,1}, {128,6}, {4,1}, {64,1}.
REQ-008 CLK  input  1: system clock; all logic is on the rising edge.
REQ-009 RST  input  1: reset, synchronous and active-high.
REQ-010 key_dec  input  1: decrement key, active-low, asynchronous to CLK.
REQ-011 key_inc  input  1: increment key, active-low, asynchronous to CLK.
REQ-012 SW  input  10: SW[3:0] selects the parameter; SW[6] is the effect enable.
REQ-013 param_val  output  NUM_PARAMS x PARAM_W: current value of each parameter.
REQ-014 param_changed  output  NUM_PARAMS: one-cycle pulse per parameter on each value change.
REQ-015 disabled  output  1: high when the effect is bypassed.

Function
REQ-016 Each key shall pass through a 2-flop synchronizer before any other logic sees it.
REQ-017 Per-key FSM shall have states RELEASED, PRESS_DB, HELD, REPEAT and RELEASE_DB.
- RELEASED -> PRESS_DB on synced low.
- PRESS_DB -> HELD after DEBOUNCE_CYCLES consecutive low cycles; this transition emits one step pulse. Any high sample returns the FSM to RELEASED.
- HELD -> REPEAT after REPEAT_DELAY further low cycles. REPEAT emits a step pulse every REPEAT_RATE cycles.
- HELD or REPEAT -> RELEASE_DB on synced high. RELEASE_DB -> RELEASED after DEBOUNCE_CYCLES consecutive high cycles; a low sample returns the FSM to its previous held state.
REQ-018 Selected index k = SW[3:0] - SEL_BASE. The selection is valid only when SEL_BASE <= SW[3:0] < SEL_BASE + NUM_PARAMS. An invalid selection discards all step pulses.
REQ-019 Decrement step: value <= max(value - P_STEP[k], P_MIN[k]). Increment step: value <= min(value + P_STEP[k], P_MAX[k]). Arithmetic is PARAM_W+1 bits wide, so there is no wrap-around.
REQ-020 If both step pulses occur in the same cycle, no change occurs and no param_changed pulse is issued.
REQ-021 Latency: param_val updates on the edge after the step pulse. param_changed[k] is high during that same following cycle only. A saturated step that leaves the value unchanged produces no pulse.
REQ-022 Changing SW[3:0] while a key is held shall redirect subsequent repeat steps to the newly selected parameter. No other state is disturbed.
REQ-023 disabled shall equal the registered value of ~SW[6], one cycle after SW[6] is sampled. It is independent of key activity.
REQ-024 Non-selected parameters hold their value.

Reset
REQ-025 On RST high at a clock edge: param_val[i] <= P_INIT[i], param_changed <= 0, disabled <= 1, both key FSMs <= RELEASED, and all counters <= 0.
REQ-026 Reset asserted mid-hold shall not emit a step. After release, a still-held key shall be re-debounced from RELEASED.

Structure
REQ-027 Package effect_ctrl_pkg shall hold the key FSM state enum, the default P_* arrays and the SW bit-position constants.
REQ-028 Sub-module key_conditioner (synchronizer + FSM + counters) shall be instantiated once per key and output a one-cycle step pulse.
REQ-029 Parameter storage and the saturating update shall stay in the top module.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, defaults otherwise)
REQ-030 Reset, then SW=0x044, one key_inc press of 10 cycles -> param_val[0] goes 64 -> 68 with one param_changed[0] pulse; param_val[1] stays 1; disabled=0.
REQ-031 SW=0x045, key_inc held 100 cycles -> param_val[1] steps 1, 2, 3, ... and saturates at 6; pulses stop at 6.
REQ-032 Key glitch: key_dec low for 3 cycles with SW=0x044 -> no change from 64 and no pulse.
REQ-033 Both keys pressed in the same cycle -> no change and no pulse. SW[3:0]=0x7 (invalid) with key_inc presses -> no change.
REQ-034 RST asserted while key_dec is in REPEAT on parameter 0 at value 20 -> value returns to 64 and no step occurs on the reset cycle.
REQ-035 SW[6] toggled 1 -> 0 -> disabled=1 one cycle later; param values unchanged.
